// File: rtl/frame_packer_pkg.sv
// Shared types and width helpers for the frame vector packer.
package frame_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // A single-element vector still needs a 1-bit index register.
  function automatic int idx_width(input int elements);
    return (elements > 1) ? $clog2(elements) : 1;
  endfunction

  localparam int DEFAULT_ELEMENTS = 2;
  localparam int ELEM_IDX_W       = idx_width(DEFAULT_ELEMENTS);

endpackage

// File: rtl/frame_packer_out_reg.sv
// Valid/ready holding register for the packed vector and its last flag.
module frame_packer_out_reg #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         last_o
);

  logic [W-1:0] data_q;
  logic         valid_q;
  logic         last_q;

  // load_i only fires when the register is empty or being drained this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule

// File: rtl/frame_vector_packer.sv
// Packs a serial element stream into ELEMENTS-wide vectors grouped into frames.
//   state      | meaning
//   ST_IDLE    | waiting for a legal frame_start, in_ready low
//   ST_COLLECT | accepting elements, emitting vectors
//   ST_DRAIN   | last vector loaded, waiting for its handshake
module frame_vector_packer
  import frame_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 33,
  parameter int ELEMENTS   = DEFAULT_ELEMENTS,
  parameter int MAX_LEN    = 1024,
  parameter int LEN_W      = len_width(MAX_LEN)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_start,
  input  logic [LEN_W-1:0]               frame_len,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [ELEMENTS*DATA_WIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           sof,
  output logic                           frame_done,
  output logic [LEN_W-1:0]               vec_cnt,
  output logic                           err_len,
  output logic                           err_busy
);

  localparam int IDX_W = (ELEMENTS == DEFAULT_ELEMENTS) ? ELEM_IDX_W : idx_width(ELEMENTS);
  localparam int ASM_N = (ELEMENTS > 1) ? ELEMENTS - 1 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMENTS - 1);

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               elem_idx_q, elem_idx_d;
  logic [LEN_W-1:0]               len_q, len_d;
  logic [LEN_W-1:0]               vec_cnt_q, vec_cnt_d;
  logic                           sof_q, sof_d;
  logic                           done_q, done_d;
  logic                           err_len_q, err_len_d;
  logic                           err_busy_q, err_busy_d;
  logic [DATA_WIDTH-1:0]          asm_q [ASM_N];
  logic [ELEMENTS*DATA_WIDTH-1:0] vec_d;
  logic                           len_ok, last_elem, accept, load, vec_last;

  assign len_ok    = (frame_len != '0) && (frame_len <= LEN_W'(MAX_LEN));
  assign last_elem = (elem_idx_q == LAST_IDX);
  // Only the vector-completing element depends on room in the output register.
  assign in_ready  = (state_q == ST_COLLECT) && (!last_elem || !out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign load      = accept && last_elem;
  assign vec_last  = ((vec_cnt_q + LEN_W'(1)) == len_q);

  always_comb begin
    vec_d = '0;
    for (int i = 0; i < ELEMENTS - 1; i++) begin
      vec_d[i*DATA_WIDTH +: DATA_WIDTH] = asm_q[i];
    end
    vec_d[(ELEMENTS-1)*DATA_WIDTH +: DATA_WIDTH] = in_data;
  end

  always_comb begin
    state_d    = state_q;
    elem_idx_d = elem_idx_q;
    len_d      = len_q;
    vec_cnt_d  = vec_cnt_q;
    sof_d      = 1'b0;
    done_d     = 1'b0;
    err_len_d  = 1'b0;
    err_busy_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          if (len_ok) begin
            len_d      = frame_len;
            vec_cnt_d  = '0;
            elem_idx_d = '0;
            sof_d      = 1'b1;
            state_d    = ST_COLLECT;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        err_busy_d = frame_start;
        if (accept) begin
          elem_idx_d = last_elem ? '0 : elem_idx_q + IDX_W'(1);
        end
        if (load) begin
          vec_cnt_d = vec_cnt_q + LEN_W'(1);
          if (vec_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        err_busy_d = frame_start;
        if (out_valid && out_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      elem_idx_q <= '0;
      len_q      <= '0;
      vec_cnt_q  <= '0;
      sof_q      <= 1'b0;
      done_q     <= 1'b0;
      err_len_q  <= 1'b0;
      err_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_idx_q <= elem_idx_d;
      len_q      <= len_d;
      vec_cnt_q  <= vec_cnt_d;
      sof_q      <= sof_d;
      done_q     <= done_d;
      err_len_q  <= err_len_d;
      err_busy_q <= err_busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ASM_N; i++) asm_q[i] <= '0;
    end else if (accept && !last_elem) begin
      for (int i = 0; i < ASM_N; i++) begin
        if (elem_idx_q == IDX_W'(i)) asm_q[i] <= in_data;
      end
    end
  end

  frame_packer_out_reg #(
    .W(ELEMENTS*DATA_WIDTH)
  ) u_out_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .data_i (vec_d),
    .last_i (vec_last),
    .ready_i(out_ready),
    .data_o (out_data),
    .valid_o(out_valid),
    .last_o (out_last)
  );

  assign sof        = sof_q;
  assign frame_done = done_q;
  assign vec_cnt    = vec_cnt_q;
  assign err_len    = err_len_q;
  assign err_busy   = err_busy_q;

endmodule

// File: tb/tb_frame_vector_packer.sv
// Directed bench for frame_vector_packer with a queue-based vector scoreboard.
module tb_frame_vector_packer;

  localparam int DW      = 33;
  localparam int EL      = 2;
  localparam int MAX_LEN = 1024;
  localparam int LEN_W   = 11;
  localparam int VW      = EL * DW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_start = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic [DW-1:0]    in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [VW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_last;
  logic             sof;
  logic             frame_done;
  logic [LEN_W-1:0] vec_cnt;
  logic             err_len;
  logic             err_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [VW-1:0] data;
    logic          last;
  } exp_t;

  exp_t expq[$];
  exp_t cmp_x;
  exp_t push_x;

  always #5 clk = ~clk;

  frame_vector_packer #(
    .DATA_WIDTH(DW),
    .ELEMENTS  (EL),
    .MAX_LEN   (MAX_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .frame_len  (frame_len),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .sof        (sof),
    .frame_done (frame_done),
    .vec_cnt    (vec_cnt),
    .err_len    (err_len),
    .err_busy   (err_busy)
  );

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Vector j of a frame whose elements are base, base+1, ...; element 0 sits in the low bits.
  function automatic logic [VW-1:0] pack_vec(input int base, input int j);
    logic [VW-1:0] v;
    v = '0;
    for (int e = 0; e < EL; e++) v[e*DW +: DW] = DW'(base + j*EL + e);
    return v;
  endfunction

  task automatic push_frame(input int len, input int base);
    for (int j = 0; j < len; j++) begin
      push_x.data = pack_vec(base, j);
      push_x.last = (j == len - 1);
      expq.push_back(push_x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int len);
    frame_start = 1'b1;
    frame_len   = LEN_W'(len);
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_elems(input int n, input int base, input bit hold_valid);
    bit acc;
    int guard;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(base + i);
      acc      = 1'b0;
      guard    = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        guard++;
        if (!acc && guard > 50) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout element=%0d actual=not_accepted required=accepted", base + i);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = hold_valid;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("frame_done_seen", frame_done, 1);
    tick();
    check("frame_done_pulse", frame_done, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_sof"}, sof, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_vec_cnt"}, vec_cnt, 0);
    check({tag, "_err_len"}, err_len, 0);
    check({tag, "_err_busy"}, err_busy, 0);
  endtask

  // Scoreboard: every handshake pops the next expected vector; stalled vectors must not move.
  logic [VW-1:0] held_data;
  logic          held_last;
  bit            held = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_data);
        check("hold_last", out_last, held_last);
      end
      if (out_valid) begin
        if (out_ready) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_vector actual=%0h required=none", out_data);
          end else begin
            cmp_x = expq.pop_front();
            check("vec_data", out_data, cmp_x.data);
            check("vec_last", out_last, cmp_x.last);
          end
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_data = out_data;
          held_last = out_last;
        end
      end else begin
        held = 1'b0;
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    bit stall_ok;

    // Reset
    repeat (3) tick();
    check_reset_outputs("rst_low");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_reset_outputs("rst_rel");

    // Frame of 3 vectors, no backpressure
    push_frame(3, 1);
    start_frame(3);
    check("t1_sof", sof, 1);
    check("t1_in_ready", in_ready, 1);
    check("t1_vec_cnt0", vec_cnt, 0);
    send_elems(6, 1, 1'b0);
    check("t1_latency_valid", out_valid, 1);
    check("t1_last_vec_data", out_data, {33'd6, 33'd5});
    check("t1_out_last", out_last, 1);
    check("t1_drain_in_ready", in_ready, 0);
    tick();
    check("t1_frame_done", frame_done, 1);
    check("t1_vec_cnt", vec_cnt, 3);
    tick();
    check("t1_frame_done_low", frame_done, 0);
    check("t1_queue_empty", expq.size(), 0);

    // Same frame with a 5-cycle stall after the first vector
    out_ready = 1'b0;
    push_frame(3, 11);
    start_frame(3);
    fork
      send_elems(6, 11, 1'b0);
      begin
        int n;
        n = 0;
        stall_ok = 1'b0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 20);
        check("t2_first_valid", out_valid, 1);
        check("t2_vec0", out_data, {33'd12, 33'd11});
        repeat (4) @(negedge clk);
        check("t2_still_valid", out_valid, 1);
        check("t2_vec0_held", out_data, {33'd12, 33'd11});
        check("t2_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_done();
    check("t2_vec_cnt", vec_cnt, 3);
    check("t2_queue_empty", expq.size(), 0);

    // Illegal lengths
    frame_start = 1'b1;
    frame_len   = '0;
    tick();
    frame_start = 1'b0;
    check("t3_err_len0", err_len, 1);
    check("t3_no_sof0", sof, 0);
    check("t3_in_ready0", in_ready, 0);
    tick();
    check("t3_err_len0_pulse", err_len, 0);
    frame_start = 1'b1;
    frame_len   = LEN_W'(MAX_LEN + 1);
    tick();
    frame_start = 1'b0;
    check("t3_err_len_max", err_len, 1);
    check("t3_no_sof_max", sof, 0);
    tick();
    check("t3_err_len_max_pulse", err_len, 0);
    check("t3_in_ready_idle", in_ready, 0);
    check("t3_vec_cnt_hold", vec_cnt, 3);

    // frame_start while collecting
    push_frame(2, 21);
    start_frame(2);
    check("t4_sof", sof, 1);
    tick();
    check("t4_sof_pulse", sof, 0);
    send_elems(2, 21, 1'b0);
    frame_start = 1'b1;
    frame_len   = LEN_W'(1);
    tick();
    frame_start = 1'b0;
    check("t4_err_busy", err_busy, 1);
    check("t4_no_sof", sof, 0);
    check("t4_vec_cnt1", vec_cnt, 1);
    tick();
    check("t4_err_busy_pulse", err_busy, 0);
    send_elems(2, 23, 1'b0);
    wait_done();
    check("t4_vec_cnt", vec_cnt, 2);
    check("t4_queue_empty", expq.size(), 0);

    // Reset in the middle of a 4-vector frame
    push_x.data = pack_vec(31, 0);
    push_x.last = 1'b0;
    expq.push_back(push_x);
    start_frame(4);
    send_elems(3, 31, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_mid");
    check("t5_queue_empty", expq.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push_frame(2, 41);
    start_frame(2);
    send_elems(4, 41, 1'b0);
    wait_done();
    check("t5_vec_cnt", vec_cnt, 2);
    check("t5_queue_empty2", expq.size(), 0);

    // Back-to-back frames, restart in the frame_done cycle
    push_frame(1, 51);
    start_frame(1);
    send_elems(2, 51, 1'b1);
    tick();
    check("t6_frame_done", frame_done, 1);
    frame_start = 1'b1;
    frame_len   = LEN_W'(2);
    push_frame(2, 61);
    tick();
    frame_start = 1'b0;
    check("t6_sof", sof, 1);
    check("t6_in_ready", in_ready, 1);
    t0 = $time;
    send_elems(4, 61, 1'b1);
    check("t6_one_per_cycle", VW'($time - t0), 40);
    in_valid = 1'b0;
    wait_done();
    check("t6_vec_cnt", vec_cnt, 2);
    check("t6_queue_empty", expq.size(), 0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_vector_packer.md
# frame_vector_packer

Synthesizable stage directly upstream of the output monitor. It takes the UUT's serial element stream and packs each group of ELEMENTS consecutive elements into one output vector. It also groups vectors into frames whose length is programmed at frame start, and generates the start-of-frame and per-vector valid strobes the monitor keys on. Output uses a valid/ready handshake so a downstream capture stage may stall it.

## Interface
- DATA_WIDTH, 33, width of one element
- ELEMENTS, 2, elements per output vector (≥1)
- MAX_LEN, 1024, maximum vectors per frame
- LEN_W, $clog2(MAX_LEN+1), width of frame length/count fields
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- frame_start  in  1  one-cycle request to open a frame
- frame_len  in  LEN_W  vectors in the frame, sampled with frame_start
- in_data  in  DATA_WIDTH  element
- in_valid  in  1  element valid
- in_ready  out  1  element accepted when in_valid & in_ready
- out_data  out  ELEMENTS*DATA_WIDTH  vector; element 0 in bits [DATA_WIDTH-1:0]
- out_valid  out  1  vector valid, held until out_ready
- out_ready  in  1  downstream accepts
- out_last  out  1  qualifies out_valid: last vector of frame
- sof  out  1  one-cycle pulse, frame opened
- frame_done  out  1  one-cycle pulse, last vector handed off
- vec_cnt  out  LEN_W  vectors emitted in current frame
- err_len  out  1  one-cycle pulse, frame_len of 0 or above MAX_LEN
- err_busy  out  1  one-cycle pulse, frame_start while not IDLE

## Operation
- States: IDLE, COLLECT, DRAIN.
- IDLE: in_ready=0. frame_start with 1≤frame_len≤MAX_LEN latches the length, clears vec_cnt and elem_idx, pulses sof on the next cycle, and moves to COLLECT. An illegal frame_len pulses err_len and stays in IDLE.
- COLLECT: elements are accepted in order. Elements 0..ELEMENTS-2 go into assembly registers. Elements with elem_idx < ELEMENTS-1 are always accepted.
- Last element of a vector: in_ready = !out_valid | out_ready. On acceptance, the assembly registers plus in_data load the output register on the same edge. out_valid is set, vec_cnt increments and elem_idx returns to 0.
- When the loaded vector is number frame_len, out_last is set with it, in_ready drops and the state moves to DRAIN.
- DRAIN: out_valid & out_ready pulses frame_done on the following cycle and returns to IDLE.
- frame_start outside IDLE is ignored and pulses err_busy. It may be re-issued in the cycle frame_done is high.
- ELEMENTS=1: every accepted element loads the output register directly.
- vec_cnt holds its final value until the next legal frame_start.

## Timing
- Reset values: in_ready=0, out_valid=0, out_last=0, out_data=0, sof=0, frame_done=0, vec_cnt=0, err_len=0, err_busy=0. State is IDLE and elem_idx=0.
- Reset mid-frame clears all state immediately. A partial vector and any pending output are discarded.
- frame_start accepted at edge k: sof high in cycle k+1, in_ready high from cycle k+1.
- Latency: last element accepted at edge k, so out_valid is high from cycle k+1.
- Throughput: one element per cycle while out_ready stays high. No bubble between vectors.
- out_data and out_last are stable while out_valid & !out_ready.
- frame_done is high one cycle after the final handshake.
- All error pulses are registered and last one cycle.

## Structure
- Shared package frame_packer_pkg holds:
  - state enum type
  - LEN_W computation function
  - element-index width localparam
- One sub-module, frame_packer_out_reg: the valid/ready holding register for out_data/out_last. All else is inline.

## Test plan
- Reset, then frame_start with frame_len=3 and ELEMENTS=2; stream elements 1..6 with out_ready=1 -> sof one cycle after start; vectors {1,2},{3,4},{5,6}; out_last only on {5,6}; frame_done one cycle after it; vec_cnt=3.
- Same frame with out_ready=0 for 5 cycles after the first vector -> in_ready low on the 4th element; vector {1,2} held stable; no element lost or duplicated.
- frame_len=0, then frame_len=MAX_LEN+1 -> err_len pulses twice; state stays IDLE; in_ready stays 0.
- frame_start issued during COLLECT -> err_busy pulses; the current frame's length and vec_cnt are unaffected.
- Assert rst_n after 3 elements of a frame_len=4 frame -> all outputs at reset values; a new frame of 2 vectors completes with fresh data only.
- Back-to-back frames (len 1, then len 2) with frame_start in the frame_done cycle -> second sof follows with no lost elements; in_valid tied high gives one element per cycle.
